// File: rtl/conv_stream_engine.sv
// Streaming 3x3 convolution engine: raster pixels in, one clamped result per
// interior window out, with a bypass mode. Three pipeline stages share one advance.
module conv_stream_engine #(
  parameter int DW    = 8,
  parameter int IMG_W = 320,
  parameter int KW    = 4,
  parameter int SHW   = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic              s_sof,
  input  logic [9*KW-1:0]   kernel,
  input  logic [SHW-1:0]    shift,
  input  logic [1:0]        mode,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic              m_sof
);

  localparam int SW = DW + KW + 5;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = 12;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = '1;
  localparam logic [DW-1:0] PIX_MAX = '1;
  localparam logic signed [SW-1:0] PIX_MAX_S = {{(SW-DW){1'b0}}, {DW{1'b1}}};
  localparam logic [SW-1:0] PIX_MAX_U = {{(SW-DW){1'b0}}, {DW{1'b1}}};

  function automatic logic signed [SW-1:0] f_mul(input logic [DW-1:0] p, input logic [KW-1:0] k);
    logic signed [SW-1:0] ps;
    logic signed [SW-1:0] ks;
    ps = {{(SW-DW){1'b0}}, p};
    ks = {{(SW-KW){k[KW-1]}}, k};
    return ps * ks;
  endfunction

  function automatic logic [DW-1:0] f_clamp_conv(input logic signed [SW-1:0] sum, input logic [SHW-1:0] sh);
    logic signed [SW-1:0] t;
    t = sum >>> sh;
    if (t[SW-1]) return '0;
    if (t > PIX_MAX_S) return PIX_MAX;
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] f_clamp_abs(input logic signed [SW-1:0] sum, input logic [SHW-1:0] sh);
    logic [SW-1:0] a;
    a = sum[SW-1] ? -sum : sum;
    a = a >> sh;
    if (a > PIX_MAX_U) return PIX_MAX;
    return a[DW-1:0];
  endfunction

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic [1:0]           r_mode;
  logic [9*KW-1:0]      r_kern;
  logic [SHW-1:0]       r_shift;
  logic [DW-1:0]        r_lb0 [IMG_W];
  logic [DW-1:0]        r_lb1 [IMG_W];

  logic                 r_vld_p0, r_sof_p0;
  logic [1:0]           r_mode_p0;
  logic [SHW-1:0]       r_shift_p0;
  logic [DW-1:0]        r_win_p0 [9];

  logic                 r_vld_p1, r_sof_p1;
  logic [1:0]           r_mode_p1;
  logic [SHW-1:0]       r_shift_p1;
  logic signed [SW-1:0] r_sum_p1;
  logic [DW-1:0]        r_byp_p1;

  logic                 r_vld_p2, r_sof_p2;
  logic [DW-1:0]        r_data_p2;

  logic                 w_adv, w_acc, w_byp, w_inner, w_center, w_byp_p1;
  logic [CW-1:0]        w_col, w_col_nxt;
  logic [RW-1:0]        w_row, w_row_nxt;
  logic [1:0]           w_mode;
  logic [SHW-1:0]       w_shift;
  logic signed [SW-1:0] w_sum;

  assign w_adv     = ~r_vld_p2 | m_ready;
  assign w_acc     = s_valid & w_adv;
  // A start-of-frame pixel is positioned and configured as if the latch had already happened.
  assign w_col     = s_sof ? '0 : r_col;
  assign w_row     = s_sof ? '0 : r_row;
  assign w_mode    = s_sof ? mode : r_mode;
  assign w_shift   = s_sof ? shift : r_shift;
  assign w_byp     = ~(w_mode[1] ^ w_mode[0]);
  assign w_inner   = (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_center  = (w_row == RW'(2)) && (w_col == CW'(2));
  assign w_col_nxt = (w_col == COL_LAST) ? '0 : w_col + 1'b1;
  assign w_row_nxt = ((w_col == COL_LAST) && (w_row != ROW_MAX)) ? w_row + 1'b1 : w_row;
  assign w_byp_p1  = ~(r_mode_p1[1] ^ r_mode_p1[0]);

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++)
      w_sum = w_sum + f_mul(r_win_p0[i], r_kern[i*KW +: KW]);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_mode     <= 2'b00;
      r_kern     <= '0;
      r_shift    <= '0;
      r_vld_p0   <= 1'b0;
      r_sof_p0   <= 1'b0;
      r_mode_p0  <= 2'b00;
      r_shift_p0 <= '0;
      r_vld_p1   <= 1'b0;
      r_sof_p1   <= 1'b0;
      r_mode_p1  <= 2'b00;
      r_shift_p1 <= '0;
      r_vld_p2   <= 1'b0;
      r_sof_p2   <= 1'b0;
      r_data_p2  <= '0;
    end else begin
      if (w_acc) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        if (s_sof) begin
          r_mode  <= mode;
          r_kern  <= kernel;
          r_shift <= shift;
        end
      end
      if (w_adv) begin
        // S1: window update
        r_vld_p0   <= w_acc & (w_byp | w_inner);
        r_sof_p0   <= w_acc & (w_byp ? s_sof : w_center);
        r_mode_p0  <= w_mode;
        r_shift_p0 <= w_shift;
        // S2: 9-tap sum
        r_vld_p1   <= r_vld_p0;
        r_sof_p1   <= r_sof_p0;
        r_mode_p1  <= r_mode_p0;
        r_shift_p1 <= r_shift_p0;
        // S3: shift and clamp
        r_vld_p2   <= r_vld_p1;
        r_sof_p2   <= r_sof_p1;
        r_data_p2  <= w_byp_p1 ? r_byp_p1 :
                      (r_mode_p1 == 2'b01) ? f_clamp_conv(r_sum_p1, r_shift_p1) :
                                             f_clamp_abs(r_sum_p1, r_shift_p1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_acc) begin
      r_win_p0[0] <= r_win_p0[1];
      r_win_p0[1] <= r_win_p0[2];
      r_win_p0[2] <= r_lb1[w_col];
      r_win_p0[3] <= r_win_p0[4];
      r_win_p0[4] <= r_win_p0[5];
      r_win_p0[5] <= r_lb0[w_col];
      r_win_p0[6] <= r_win_p0[7];
      r_win_p0[7] <= r_win_p0[8];
      r_win_p0[8] <= s_data;
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= s_data;
    end
    if (w_adv) begin
      r_sum_p1 <= w_sum;
      r_byp_p1 <= r_win_p0[8];
    end
  end

  assign s_ready = w_adv;
  assign m_valid = r_vld_p2;
  assign m_data  = r_data_p2;
  assign m_sof   = r_sof_p2;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: directed frames plus randomized frames scored
// against an image-array reference model of the convolution rules.
module tb_conv_stream_engine;
  localparam int DW = 8, IMG_W = 4, KW = 4, SHW = 4;
  localparam logic [35:0] K_ID   = 36'h000010000;
  localparam logic [35:0] K_ONES = 36'h111111111;
  localparam logic [35:0] K_NEG  = 36'h0000F0000;
  localparam logic [35:0] K_SEV  = 36'h000070000;

  logic            sys_clk = 1'b0, rst = 1'b1;
  logic            s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b1;
  logic            s_ready, m_valid, m_sof;
  logic [DW-1:0]   s_data = '0, m_data;
  logic [9*KW-1:0] kernel = '0;
  logic [SHW-1:0]  shift = '0;
  logic [1:0]      mode = 2'b00;

  int n_vec = 0, n_err = 0, n_out = 0;
  int exp_q[$], got_q[$], gsof_q[$];
  bit hold_rdy = 0, rand_rdy = 0, gap_en = 0;

  int          md_mode = 0, md_shift = 0, md_row = 0, md_col = 0;
  logic [35:0] md_kern = '0;
  int          img [16][IMG_W];

  conv_stream_engine #(.DW(DW), .IMG_W(IMG_W), .KW(KW), .SHW(SHW)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .kernel(kernel), .shift(shift), .mode(mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof)
  );

  always #5 sys_clk = ~sys_clk;

  always begin
    @(posedge sys_clk);
    #1;
    m_ready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  task automatic chk_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int coef(input logic [35:0] k, input int i);
    logic [3:0] c;
    c = k[i*4 +: 4];
    return int'($signed(c));
  endfunction

  function automatic int post(input int sum, input int md, input int sh);
    int t;
    if (md == 1) begin
      t = sum >>> sh;
      if (t < 0) t = 0;
    end else begin
      t = (sum < 0) ? -sum : sum;
      t = t >> sh;
    end
    if (t > 255) t = 255;
    return t;
  endfunction

  task automatic model_reset();
    md_mode = 0; md_kern = '0; md_shift = 0; md_row = 0; md_col = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int d, input bit sof);
    int sum;
    if (sof) begin
      md_row = 0; md_col = 0;
      md_mode = int'(mode); md_kern = kernel; md_shift = int'(shift);
    end
    if (md_row < 16) img[md_row][md_col] = d;
    if (md_mode == 0 || md_mode == 3)
      exp_q.push_back(int'(sof) * 256 + d);
    else if (md_row >= 2 && md_col >= 2 && md_row < 16) begin
      sum = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          sum += coef(md_kern, r*3 + c) * img[md_row-2+r][md_col-2+c];
      exp_q.push_back(((md_row == 2 && md_col == 2) ? 256 : 0) + post(sum, md_mode, md_shift));
    end
    md_col++;
    if (md_col == IMG_W) begin
      md_col = 0;
      if (md_row < 4095) md_row++;
    end
  endtask

  always @(negedge sys_clk) begin
    int e;
    if (!rst && m_valid && m_ready) begin
      got_q.push_back(int'(m_data));
      gsof_q.push_back(int'(m_sof));
      n_out++;
      if (exp_q.size() == 0) chk_val("unexpected_output", int'(m_data), -1);
      else begin
        e = exp_q.pop_front();
        chk_val("out_data", int'(m_data), e % 256);
        chk_val("out_sof", int'(m_sof), e / 256);
      end
    end
  end

  task automatic send_pix(input int d, input bit sof);
    int  waitc;
    bit  done;
    waitc = 0; done = 0;
    s_valid = 1'b1; s_data = 8'(d); s_sof = sof;
    while (!done) begin
      @(negedge sys_clk);
      if (s_ready) begin
        model_accept(d, sof);
        done = 1;
      end else if (++waitc > 300) begin
        $display("FAIL accept_timeout: got no s_ready, expected s_ready within 300 cycles");
        $fatal(1, "stuck");
      end
      @(posedge sys_clk);
      #1;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge sys_clk); #1; end
  endtask

  task automatic run_frame(input int nrows, input int kind, input int val);
    int d;
    for (int i = 0; i < nrows*IMG_W; i++) begin
      d = (kind == 0) ? i : (kind == 1) ? val : int'($urandom_range(0, 255));
      send_pix(d, i == 0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge sys_clk); t++; end
    chk_val("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_obs();
    got_q.delete(); gsof_q.delete(); n_out = 0;
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic [35:0] k, input logic [3:0] sh);
    mode = md; kernel = k; shift = sh;
  endtask

  task automatic chk_frame(input string tag, input int n, input int val);
    chk_val({tag, "_count"}, n_out, n);
    for (int i = 0; i < got_q.size(); i++) chk_val({tag, "_value"}, got_q[i], val);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int exp36 [4] = '{5, 6, 9, 10};
    int nr, cut, d0;
    logic [63:0] tmp;

    repeat (2) begin
      @(negedge sys_clk);
      chk_val("rst_m_valid", int'(m_valid), 0);
      chk_val("rst_m_data", int'(m_data), 0);
      chk_val("rst_m_sof", int'(m_sof), 0);
      chk_val("rst_s_ready", int'(s_ready), 1);
    end
    @(posedge sys_clk); #1;
    rst = 1'b0;
    @(negedge sys_clk);
    chk_val("post_rst_s_ready", int'(s_ready), 1);
    chk_val("post_rst_m_valid", int'(m_valid), 0);
    @(posedge sys_clk); #1;

    set_cfg(2'b00, '0, 4'd0);
    clr_obs();
    send_pix(165, 1'b1);
    @(negedge sys_clk); chk_val("lat_cycle0", int'(m_valid), 0);
    @(negedge sys_clk); chk_val("lat_cycle1", int'(m_valid), 0);
    @(negedge sys_clk); chk_val("lat_cycle2", int'(m_valid), 1);
    chk_val("lat_data", int'(m_data), 165);
    @(posedge sys_clk); #1;
    drain();

    set_cfg(2'b01, K_ID, 4'd0);
    clr_obs();
    run_frame(4, 0, 0);
    drain();
    chk_val("ident_count", n_out, 4);
    for (int i = 0; i < 4; i++) begin
      chk_val("ident_value", (i < got_q.size()) ? got_q[i] : -1, exp36[i]);
      chk_val("ident_sof", (i < gsof_q.size()) ? gsof_q[i] : -1, (i == 0) ? 1 : 0);
    end

    set_cfg(2'b01, K_ONES, 4'd3);
    clr_obs(); run_frame(4, 1, 80); drain();
    chk_frame("ones_shift3", 4, 90);

    set_cfg(2'b01, K_NEG, 4'd0);
    clr_obs(); run_frame(4, 1, 50); drain();
    chk_frame("neg_clamp0", 4, 0);
    set_cfg(2'b10, K_NEG, 4'd0);
    clr_obs(); run_frame(4, 1, 50); drain();
    chk_frame("neg_abs", 4, 50);
    set_cfg(2'b01, K_SEV, 4'd0);
    clr_obs(); run_frame(4, 1, 200); drain();
    chk_frame("sev_clamp255", 4, 255);

    set_cfg(2'b00, '0, 4'd0);
    clr_obs();
    fork
      run_frame(4, 2, 0);
      begin
        nr = 0;
        while (n_out < 6 && nr < 300) begin @(negedge sys_clk); nr++; end
        hold_rdy = 1;
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        d0 = int'(m_data);
        chk_val("stall_valid_start", int'(m_valid), 1);
        repeat (4) begin
          @(negedge sys_clk);
          chk_val("stall_valid", int'(m_valid), 1);
          chk_val("stall_data", int'(m_data), d0);
          chk_val("stall_s_ready", int'(s_ready), 0);
        end
        hold_rdy = 0;
      end
    join
    drain();
    chk_val("bypass_count", n_out, 16);

    set_cfg(2'b01, K_ID, 4'd0);
    clr_obs();
    for (int i = 0; i < 9; i++) send_pix(100 + i, i == 0);
    run_frame(4, 0, 0);
    drain();
    chk_val("resof_count", n_out, 4);
    chk_val("resof_first_sof", (gsof_q.size() > 0) ? gsof_q[0] : -1, 1);
    chk_val("resof_first_data", (got_q.size() > 0) ? got_q[0] : -1, 5);

    clr_obs();
    for (int i = 0; i < 11; i++) send_pix(i, i == 0);
    rst = 1'b1;
    model_reset();
    @(negedge sys_clk);
    chk_val("midrst_m_valid", int'(m_valid), 0);
    chk_val("midrst_m_data", int'(m_data), 0);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge sys_clk); #1; end
    chk_val("midrst_no_output", n_out, 0);
    run_frame(4, 0, 0);
    drain();
    chk_val("midrst_resume_count", n_out, 4);
    chk_val("midrst_resume_sof", (gsof_q.size() > 0) ? gsof_q[0] : -1, 1);

    rand_rdy = 1; gap_en = 1;
    for (int f = 0; f < 12; f++) begin
      tmp = {$urandom(), $urandom()};
      set_cfg(2'($urandom_range(0, 3)), tmp[35:0], 4'($urandom_range(0, 4)));
      nr = $urandom_range(3, 5);
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nr*IMG_W - 1)) : nr*IMG_W;
      for (int i = 0; i < cut; i++) begin
        send_pix(int'($urandom_range(0, 255)), i == 0);
        if (i == 5) begin
          tmp = {$urandom(), $urandom()};
          set_cfg(2'($urandom_range(0, 3)), tmp[35:0], 4'($urandom_range(0, 15)));
        end
      end
    end
    drain();
    rand_rdy = 0; gap_en = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
